tqvp_hx2003_pulse_receiver: RTL and testbench
=============================================

# tqvp_hx2003_pulse_receiver

TinyQV peripheral that captures a pulse train on a selectable `ui_in` pin. It records each level run as a {level, duration} entry in a 16-entry capture memory that the CPU reads back. It is the receive counterpart of the pulse transmitter, used for IR/RMT-style decoding. Capture stops on an idle timeout or a full buffer, and can raise an interrupt.

## Interface
Parameters:
- `NUM_ENTRIES`, 16: capture depth in 16-bit entries, packed two per 32-bit word; must be even and ≤16.

Ports:
- `clk`  in  1  project clock, 64 MHz nominal
- `rst_n`  in  1  reset, asynchronous, active-low
- `ui_in`  in  8  input PMOD, already synchronised to `clk`
- `uo_out`  out  8  bit3 = capture active; all other bits 0
- `address`  in  6  byte address within the peripheral
- `data_in`  in  32  write data
- `data_write_n`  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit
- `data_read_n`  in  2  11 none, 00/01/10 read width
- `data_out`  out  32  read data, combinational from `address`
- `data_ready`  out  1  tied 1; every read completes in 1 cycle
- `user_interrupt`  out  1  sticky capture-done interrupt

## Operation
Register map:
- 0x00 CONFIG: 32-bit write, reads back as written.
  - bit0 start
  - bit1 invert input
  - bit2 idle level
  - bit3 interrupt enable
  - bits6:4 input select (`ui_in` index)
  - bits10:7 prescaler p
  - bits25:11 idle threshold T, 15 bits; T=0 disables the timeout
  - bits31:26 glitch length G
- 0x04 STATUS, read-only:
  - bit0 armed
  - bit1 capturing
  - bit2 done
  - bit3 full
  - bit4 timeout
  - bits9:5 entry count, 0..16
- 0x10: an 8-bit write with `data_in[0]`=1 clears `user_interrupt`.
- 0x20–0x3C: capture words, read-only; word k = address[4:2].
  - Entry 2k in bits15:0, entry 2k+1 in bits31:16.
  - Entry format: bit15 = level, bits14:0 = duration.
- Unmapped reads return 0.

Signal path:
- Input s = `ui_in[sel]` XOR invert, then passed through the glitch filter (see Configuration) to give f.

FSM states: IDLE, ARMED, CAPTURE, DONE.
- Rising edge of CONFIG.start, from any state: count, full, timeout and done are cleared; next state ARMED.
- start=0: forces IDLE on the next cycle. Count and memory are retained.
- ARMED: wait until f ≠ idle level. Then enter CAPTURE with run level = f, duration = 0 and the prescale counter cleared.
- CAPTURE, tick: a tick occurs every 2^p clocks since the run start. Each tick increments duration, saturating at 0x7FFF.
- CAPTURE, edge of f:
  - Write {run level, duration} to entry[count]; count++.
  - Duration and prescaler restart, and the run level flips.
  - If count becomes NUM_ENTRIES: set full, go DONE.
- CAPTURE, timeout: run level = idle level, T≠0 and duration reaches T → set timeout, go DONE. The idle run is not stored.
- An edge and a timeout in the same cycle: the edge wins (entry written, no timeout).
- DONE: holds until the next start rising edge.
- Interrupt:
  - On entry to DONE with interrupt enable set, `user_interrupt` is set.
  - If the interrupt is set and cleared in the same cycle, set wins.

## Timing
- Reset asserted: state IDLE; CONFIG, STATUS, count and `user_interrupt` are 0; `uo_out`=0. Capture memory is not reset. Reset mid-capture aborts immediately.
- Edge detection compares f with its registered copy, so an edge is seen 1 cycle after f changes. The entry write happens in that same cycle; count and memory are visible to reads on the next cycle.
- Duration with glitch filtering off: a run stable for N cycles records floor(N / 2^p), saturating.
- Start detection: start rising edge → ARMED 1 cycle after the CONFIG write.
- DONE → `user_interrupt` high 1 cycle later.
- A rising edge of f while ARMED produces CAPTURE 1 cycle later.

## Configuration
- Macro `PULSE_RECEIVER_GLITCH_FILTER_EN`.
- Defined: f changes only after s has differed from f for G+1 consecutive cycles. All edges are delayed by G+1 cycles, so clean durations are unchanged. Pulses ≤G cycles are absorbed into the surrounding run.
- Undefined: f = s. G bits still read back but are ignored.

## Test plan
- p=0, T=100, idle=0, select bit0: drive high 10 cycles, low 20, high 5, then low → entries 0x800A, 0x0014, 0x8005; timeout=1, count=3, IRQ set.
- p=2: drive a 37-cycle high pulse → entry 0x8009.
- T=0: drive 20 toggles → first 16 entries stored, full=1, count=16, further edges ignored.
- Assert start=0 mid-capture, then start=1 → count 0, ARMED. Async reset mid-capture → all outputs 0 immediately.
- Filter enabled, G=3: inject a 2-cycle glitch in a 50-cycle high run → single 50-duration entry. With the filter compiled out, the same stimulus gives 3 entries.
- IRQ set, then 8-bit write 0x01 to 0x10 → `user_interrupt`=0 the next cycle. A DONE event in the same cycle keeps it 1.

Source files
------------

// File: rtl/tqvp_hx2003_pulse_receiver_if.sv
// TinyQV peripheral register bus between the CPU (master) and the pulse receiver (slave).
interface tqvp_hx2003_pulse_receiver_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// Pulse-train receiver: records {level, duration} runs of one ui_in pin into a capture memory.
// Optional glitch filter compiled in with `define PULSE_RECEIVER_GLITCH_FILTER_EN.
module tqvp_hx2003_pulse_receiver #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         ui_in,
    output logic [7:0]                         uo_out,
    tqvp_hx2003_pulse_receiver_if.slave        bus,
    output logic                               user_interrupt
);
    localparam int AW = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] config_reg;
    logic [31:0] config_wmask;
    logic [4:0]  count_reg, count_next;
    logic        full_reg, full_next;
    logic        timeout_reg, timeout_next;
    logic        done_reg, done_next;
    logic        run_level_reg, run_level_next;
    logic [14:0] duration_reg, duration_next;
    logic [14:0] presc_reg, presc_next;
    logic        f_reg;
    logic        irq_reg;
    logic        done_pulse_reg;
    logic        done_enter;
    logic        mem_we;
    logic [15:0] mem [NUM_ENTRIES];
    logic [31:0] word [8];

    logic        cfg_write, start_rise, irq_clear;
    logic        invert, idle_level, irq_en;
    logic [2:0]  sel;
    logic [3:0]  prescale;
    logic [14:0] thresh;
    logic [5:0]  glitch_len;
    logic        s, f, f_edge, tick;
    logic [14:0] presc_mask, dur_inc;
    logic [1:0]  unused_read;

    assign invert     = config_reg[1];
    assign idle_level = config_reg[2];
    assign irq_en     = config_reg[3];
    assign sel        = config_reg[6:4];
    assign prescale   = config_reg[10:7];
    assign thresh     = config_reg[25:11];
    assign glitch_len = config_reg[31:26];
    assign unused_read = bus.data_read_n;

    assign cfg_write  = (bus.address == 6'h00) && (bus.data_write_n != 2'b11);
    // Start edge is taken from the write data so ARMED is reached in the write's own clock edge.
    assign start_rise = cfg_write && bus.data_in[0] && !config_reg[0];
    assign irq_clear  = (bus.address == 6'h10) && (bus.data_write_n != 2'b11) && bus.data_in[0];

    always_comb begin
        case (bus.data_write_n)
            2'b00:   config_wmask = 32'h0000_00FF;
            2'b01:   config_wmask = 32'h0000_FFFF;
            default: config_wmask = 32'hFFFF_FFFF;
        endcase
    end

    assign s = ui_in[sel] ^ invert;

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
    logic       filt_reg;
    logic [5:0] glitch_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_reg       <= 1'b0;
            glitch_cnt_reg <= '0;
        end else if (s == filt_reg) begin
            glitch_cnt_reg <= '0;
        end else if (glitch_cnt_reg == glitch_len) begin
            filt_reg       <= s;
            glitch_cnt_reg <= '0;
        end else begin
            glitch_cnt_reg <= glitch_cnt_reg + 6'd1;
        end
    end
    assign f = filt_reg;
`else
    logic unused_glitch;
    assign unused_glitch = ^glitch_len;
    assign f = s;
`endif

    assign f_edge     = (f != f_reg);
    assign presc_mask = (15'd1 << prescale) - 15'd1;
    assign tick       = (presc_reg == presc_mask);
    // The cycle in which an edge is seen still belongs to the run that is ending.
    assign dur_inc    = (tick && duration_reg != 15'h7FFF) ? duration_reg + 15'd1 : duration_reg;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        full_next      = full_reg;
        timeout_next   = timeout_reg;
        done_next      = done_reg;
        run_level_next = run_level_reg;
        duration_next  = duration_reg;
        presc_next     = presc_reg;
        mem_we         = 1'b0;
        done_enter     = 1'b0;
        if (start_rise) begin
            state_next   = ARMED;
            count_next   = '0;
            full_next    = 1'b0;
            timeout_next = 1'b0;
            done_next    = 1'b0;
        end else if (!config_reg[0]) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (f != idle_level) begin
                        state_next     = CAPTURE;
                        run_level_next = f;
                        duration_next  = '0;
                        presc_next     = '0;
                    end
                end
                CAPTURE: begin
                    presc_next    = tick ? 15'd0 : presc_reg + 15'd1;
                    duration_next = dur_inc;
                    if (f_edge) begin
                        mem_we         = 1'b1;
                        count_next     = count_reg + 5'd1;
                        duration_next  = '0;
                        presc_next     = '0;
                        run_level_next = ~run_level_reg;
                        if (count_reg == 5'(NUM_ENTRIES - 1)) begin
                            full_next  = 1'b1;
                            done_next  = 1'b1;
                            state_next = DONE;
                            done_enter = 1'b1;
                        end
                    end else if (run_level_reg == idle_level && thresh != 15'd0 && dur_inc == thresh) begin
                        timeout_next = 1'b1;
                        done_next    = 1'b1;
                        state_next   = DONE;
                        done_enter   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            config_reg     <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            done_reg       <= 1'b0;
            run_level_reg  <= 1'b0;
            duration_reg   <= '0;
            presc_reg      <= '0;
            f_reg          <= 1'b0;
            irq_reg        <= 1'b0;
            done_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            full_reg       <= full_next;
            timeout_reg    <= timeout_next;
            done_reg       <= done_next;
            run_level_reg  <= run_level_next;
            duration_reg   <= duration_next;
            presc_reg      <= presc_next;
            f_reg          <= f;
            done_pulse_reg <= done_enter && irq_en;
            if (cfg_write)
                config_reg <= (config_reg & ~config_wmask) | (bus.data_in & config_wmask);
            // A set arriving together with a clear wins.
            if (done_pulse_reg)
                irq_reg <= 1'b1;
            else if (irq_clear)
                irq_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[count_reg[AW-1:0]] <= {run_level_reg, dur_inc};
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_word
        if (2 * gi < NUM_ENTRIES) begin : g_used
            assign word[gi] = {mem[2*gi+1], mem[2*gi]};
        end else begin : g_empty
            assign word[gi] = '0;
        end
    end

    always_comb begin
        bus.data_out = '0;
        if (bus.address[5])
            bus.data_out = word[bus.address[4:2]];
        else if (bus.address == 6'h00)
            bus.data_out = config_reg;
        else if (bus.address == 6'h04)
            bus.data_out = {22'd0, count_reg, timeout_reg, full_reg, done_reg,
                            state_reg == CAPTURE, state_reg == ARMED};
    end

    assign bus.data_ready  = 1'b1;
    assign uo_out          = {4'd0, state_reg == CAPTURE, 3'd0};
    assign user_interrupt  = irq_reg;
endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Self-checking bench: directed vector table, hand sequences and randomized pulse trains vs a run-length model.
module tb_tqvp_hx2003_pulse_receiver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic       user_interrupt;

    tqvp_hx2003_pulse_receiver_if bus();

    tqvp_hx2003_pulse_receiver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .bus            (bus),
        .user_interrupt (user_interrupt)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   pin_sel = 0;
    logic pin_inv = 1'b0;

    typedef struct {
        int          p;
        int          n;
        logic [15:0] exp_entry;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    function automatic logic [31:0] mk_cfg(input logic start, input logic inv, input logic idle,
                                           input logic ie, input int sel, input int p,
                                           input int t, input int g);
        return {6'(g), 15'(t), 4'(p), 3'(sel), ie, idle, inv, start};
    endfunction

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
        bus.address      = a;
        bus.data_in      = d;
        bus.data_write_n = w;
        @(posedge clk);
        #1;
        bus.data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        bus.address     = a;
        bus.data_read_n = 2'b10;
        @(negedge clk);
        d = bus.data_out;
        bus.data_read_n = 2'b11;
    endtask

    task automatic set_pin(input logic lvl);
        ui_in = 8'($urandom);
        ui_in[pin_sel] = lvl ^ pin_inv;
    endtask

    task automatic drive(input logic lvl, input int n);
        set_pin(lvl);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_capture(input logic [31:0] cfg);
        bus_write(6'h00, cfg & ~32'h1, 2'b10);
        bus_write(6'h00, cfg | 32'h1, 2'b10);
    endtask

    task automatic wait_done(input string name, input int limit);
        logic [31:0] st;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            bus_read(6'h04, st);
            seen = st[2];
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: done flag got 0 after %0d cycles, expected 1", name, limit);
        end
    endtask

    task automatic check_entry(input string name, input int k, input logic [15:0] exp);
        logic [31:0] w;
        bus_read(6'(32 + (k >> 1) * 4), w);
        check(name, (k & 1) ? {16'd0, w[31:16]} : {16'd0, w[15:0]}, {16'd0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          p, t, nr, d, len;
        logic        idle, inv, lvl;
        int          lens[$];
        logic [15:0] exp_q[$];
        bit          exp_full, exp_to;

        vecs[0] = '{p: 0, n: 10,  exp_entry: 16'h800A};
        vecs[1] = '{p: 2, n: 37,  exp_entry: 16'h8009};
        vecs[2] = '{p: 1, n: 7,   exp_entry: 16'h8003};
        vecs[3] = '{p: 3, n: 5,   exp_entry: 16'h8000};
        vecs[4] = '{p: 0, n: 1,   exp_entry: 16'h8001};
        vecs[5] = '{p: 4, n: 100, exp_entry: 16'h8006};

        rst_n = 1'b0;
        ui_in = 8'h00;
        bus.address = 6'h00;
        bus.data_in = '0;
        bus.data_write_n = 2'b11;
        bus.data_read_n = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        bus_read(6'h04, rd); check("reset_status", rd, 32'h0);
        bus_read(6'h00, rd); check("reset_config", rd, 32'h0);
        check("reset_uo_out", {24'd0, uo_out}, 32'h0);
        check("reset_irq", {31'd0, user_interrupt}, 32'h0);
        check("data_ready", {31'd0, bus.data_ready}, 32'h1);

        // Three-run capture ending in a timeout
        pin_sel = 0; pin_inv = 1'b0;
        set_pin(1'b0);
        start_capture(mk_cfg(1, 0, 0, 1, 0, 0, 100, 0));
        bus_read(6'h00, rd); check("config_readback", rd, mk_cfg(1, 0, 0, 1, 0, 0, 100, 0));
        drive(1'b0, 3);
        drive(1'b1, 10);
        drive(1'b0, 20);
        drive(1'b1, 5);
        set_pin(1'b0);
        wait_done("basic_done", 300);
        bus_read(6'h04, rd); check("basic_status", rd, 32'h74);
        bus_read(6'h20, rd); check("basic_word0", rd, 32'h0014_800A);
        check_entry("basic_entry2", 2, 16'h8005);
        @(posedge clk); #1;
        check("basic_irq_set", {31'd0, user_interrupt}, 32'h1);
        bus_write(6'h10, 32'h1, 2'b00);
        check("irq_clear", {31'd0, user_interrupt}, 32'h0);

        // Single-pulse prescaler vectors
        for (int i = 0; i < 6; i++) begin
            set_pin(1'b0);
            start_capture(mk_cfg(1, 0, 0, 0, 0, vecs[i].p, 1, 0));
            drive(1'b0, 2);
            drive(1'b1, vecs[i].n);
            set_pin(1'b0);
            wait_done($sformatf("vec%0d_done", i), 200);
            bus_read(6'h20, rd);
            check($sformatf("vec%0d_entry", i), {16'd0, rd[15:0]}, {16'd0, vecs[i].exp_entry});
            bus_read(6'h04, rd);
            check($sformatf("vec%0d_status", i), rd, 32'h34);
        end

        // Buffer fills after 16 edges; later edges are ignored
        set_pin(1'b0);
        start_capture(mk_cfg(1, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 2);
        for (int k = 0; k < 20; k++) drive(((k & 1) == 0), k + 1);
        set_pin(1'b0);
        wait_done("full_done", 50);
        bus_read(6'h04, rd); check("full_status", rd, 32'h20C);
        for (int j = 0; j < 8; j++) begin
            bus_read(6'(32 + 4 * j), rd);
            check($sformatf("full_word%0d", j), rd, {16'(2 * j + 2), 16'h8000 | 16'(2 * j + 1)});
        end

        // start=0 mid-capture, then a fresh start
        set_pin(1'b0);
        start_capture(mk_cfg(1, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 2);
        drive(1'b1, 5);
        drive(1'b0, 5);
        bus_write(6'h00, mk_cfg(0, 0, 0, 0, 0, 0, 0, 0), 2'b10);
        @(posedge clk); #1;
        bus_read(6'h04, rd); check("stop_status", rd, 32'h20);
        bus_write(6'h00, mk_cfg(1, 0, 0, 0, 0, 0, 0, 0), 2'b10);
        bus_read(6'h04, rd); check("restart_status", rd, 32'h01);

        // Glitch in a high run
        set_pin(1'b0);
        start_capture(mk_cfg(1, 0, 0, 0, 0, 0, 5, 3));
        drive(1'b0, 2);
        drive(1'b1, 24);
        drive(1'b0, 2);
        drive(1'b1, 24);
        set_pin(1'b0);
        wait_done("glitch_done", 100);
`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
        bus_read(6'h04, rd); check("glitch_status", rd, 32'h34);
        check_entry("glitch_entry0", 0, 16'h8032);
`else
        bus_read(6'h04, rd); check("glitch_status", rd, 32'h74);
        check_entry("glitch_entry0", 0, 16'h8018);
        check_entry("glitch_entry1", 1, 16'h0002);
        check_entry("glitch_entry2", 2, 16'h8018);
`endif

        // Interrupt set and clear in the same cycle: set wins
        set_pin(1'b0);
        start_capture(mk_cfg(1, 0, 0, 1, 0, 0, 3, 0));
        drive(1'b0, 2);
        drive(1'b1, 4);
        set_pin(1'b0);
        wait_done("setwins_done", 50);
        bus_write(6'h10, 32'h1, 2'b00);
        check("irq_set_wins", {31'd0, user_interrupt}, 32'h1);

        // Randomized trains vs run-length model
        for (int it = 0; it < 24; it++) begin
            p = $urandom_range(0, 3);
            t = $urandom_range(2, 12);
            idle = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            pin_sel = $urandom_range(0, 7);
            pin_inv = inv;
            nr = 2 * $urandom_range(0, 10) + 1;
            lens.delete();
            exp_q.delete();
            exp_full = 1'b0;
            exp_to = 1'b0;
            lvl = ~idle;
            for (int i = 0; i < nr; i++) begin
                len = (lvl == idle) ? $urandom_range(1, (t << p) - 1) : $urandom_range(1, 30);
                lens.push_back(len);
                lvl = ~lvl;
            end
            lvl = ~idle;
            foreach (lens[i]) begin
                d = lens[i] >> p;
                if (d > 32767) d = 32767;
                if (lvl == idle && d >= t) begin
                    exp_to = 1'b1;
                    break;
                end
                exp_q.push_back({lvl, 15'(d)});
                if (exp_q.size() == 16) begin
                    exp_full = 1'b1;
                    break;
                end
                lvl = ~lvl;
            end
            if (!exp_full) exp_to = 1'b1;

            set_pin(idle);
            start_capture(mk_cfg(1, inv, idle, 0, pin_sel, p, t, 0));
            drive(idle, 2);
            lvl = ~idle;
            foreach (lens[i]) begin
                drive(lvl, lens[i]);
                lvl = ~lvl;
            end
            set_pin(idle);
            wait_done($sformatf("rand%0d_done", it), (t << p) + 60);
            bus_read(6'h04, rd);
            check($sformatf("rand%0d_status", it), rd,
                  (32'(exp_q.size()) << 5) | (32'(exp_to) << 4) | (32'(exp_full) << 3) | 32'h4);
            foreach (exp_q[k])
                check_entry($sformatf("rand%0d_entry%0d", it, k), k, exp_q[k]);
        end

        // Asynchronous reset mid-capture; interrupt is still pending from above
        pin_sel = 0; pin_inv = 1'b0;
        set_pin(1'b0);
        start_capture(mk_cfg(1, 0, 0, 0, 0, 0, 0, 0));
        drive(1'b0, 2);
        drive(1'b1, 3);
        check("capture_active", {24'd0, uo_out}, 32'h08);
        #2;
        rst_n = 1'b0;
        bus.address = 6'h04;
        #1;
        check("async_uo_out", {24'd0, uo_out}, 32'h0);
        check("async_irq", {31'd0, user_interrupt}, 32'h0);
        check("async_status", bus.data_out, 32'h0);
        bus.address = 6'h00;
        #1;
        check("async_config", bus.data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
